// File: rtl/rv32i_types.sv
// ============================================================================
// Module   : rv32i_types (package)
// Purpose  : Shared types for the rv32i memory-port arbiter.
//            - arb_state_t : arbiter FSM states
//            - mem_req_t   : one latched memory request (addr/masks/wdata)
//            - ARB_STARVE_MAX : default dmem-grant limit while imem waits
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

  localparam int ARB_STARVE_MAX = 4;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between the instruction-fetch (imem) and
//            memory-stage (dmem) requesters. Requests are serialised: the
//            winner is latched on leaving IDLE, driven on mem_* until
//            mem_resp, and the response is routed back to its owner in the
//            same cycle. dmem normally wins, but imem is forced through after
//            STARVE_MAX consecutive dmem grants made while it was waiting.
// Ports    : clk, rst (async, active-high)
//            imem_addr/imem_rmask        -> fetch request (rmask!=0 = request)
//            imem_rdata/imem_resp        <- fetch response
//            dmem_addr/rmask/wmask/wdata -> data request ((rmask|wmask)!=0)
//            dmem_rdata/dmem_resp        <- data response
//            mem_addr/rmask/wmask/wdata  <- shared port request
//            mem_rdata/mem_resp          -> shared port response
//            stall                       <- pipeline freeze request
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int STARVE_MAX = ARB_STARVE_MAX,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,

  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,

  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,

  output logic        stall
);

  localparam logic [CNT_W-1:0] c_STARVE_LIMIT = CNT_W'(STARVE_MAX);

  arb_state_t       r_state;
  mem_req_t         r_req;
  logic [CNT_W-1:0] r_starve_cnt;

  logic     w_i_pend;
  logic     w_d_pend;
  logic     w_pick_d;
  logic     w_i_resp;
  logic     w_d_resp;
  mem_req_t w_i_req;
  mem_req_t w_d_req;

  assign w_i_pend = |imem_rmask;
  assign w_d_pend = |(dmem_rmask | dmem_wmask);

  // dmem has priority unless imem is waiting and has already been passed
  // over STARVE_MAX times in a row.
  assign w_pick_d = w_d_pend && !(w_i_pend && (r_starve_cnt == c_STARVE_LIMIT));

  assign w_i_req = '{addr: imem_addr, rmask: imem_rmask, wmask: 4'h0, wdata: 32'h0};
  assign w_d_req = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};

  // Single-process FSM. r_req doubles as the registered mem_* drive: it is
  // loaded on a grant and cleared when the response arrives, so the shared
  // port shows all-zero whenever the arbiter is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_starve_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_state <= SERVE_D;
            r_req   <= w_d_req;
            // Only dmem wins taken at imem's expense count toward starvation.
            // The counter cannot exceed the limit here: at the limit imem wins.
            if (w_i_pend) begin
              r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
          end else if (w_i_pend) begin
            r_state      <= SERVE_I;
            r_req        <= w_i_req;
            r_starve_cnt <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            r_state <= IDLE;
            r_req   <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= '0;
        end
      endcase
    end
  end

  assign mem_addr  = r_req.addr;
  assign mem_rmask = r_req.rmask;
  assign mem_wmask = r_req.wmask;
  assign mem_wdata = r_req.wdata;

  // A response in IDLE (spurious or left over from a reset) matches no owner.
  assign w_i_resp = (r_state == SERVE_I) && mem_resp;
  assign w_d_resp = (r_state == SERVE_D) && mem_resp;

  assign imem_resp  = w_i_resp;
  assign dmem_resp  = w_d_resp;
  assign imem_rdata = w_i_resp ? mem_rdata : 32'h0;
  assign dmem_rdata = w_d_resp ? mem_rdata : 32'h0;

  // Freeze unless every requester that is asking gets its answer this cycle.
  assign stall = (w_i_pend || w_d_pend) &&
                 !((!w_i_pend || w_i_resp) && (!w_d_pend || w_d_resp));

`ifndef SYNTHESIS
  a_imem_stable : assert property (@(posedge clk) disable iff (rst)
    (r_state == SERVE_I) |-> (imem_addr == r_req.addr && imem_rmask == r_req.rmask));

  a_dmem_stable : assert property (@(posedge clk) disable iff (rst)
    (r_state == SERVE_D) |-> (dmem_addr == r_req.addr && dmem_rmask == r_req.rmask &&
                              dmem_wmask == r_req.wmask && dmem_wdata == r_req.wdata));

  a_dmem_rw_excl : assert property (@(posedge clk) disable iff (rst)
    !((|dmem_rmask) && (|dmem_wmask)));
`endif

endmodule

`default_nettype wire
